// File: rtl/rx_buffer_if.sv
// rtl/rx_buffer_if.sv - byte-in / matrix-out bundle between the UART receiver, rx_buffer and the compute core
//
// Purpose: groups the receive strobe, the consumer acknowledge and the assembled
// matrix with its status flags so they travel as one port.
// Signals:
//   i_valid   one-cycle strobe, i_data holds a received byte
//   i_data    received byte
//   i_ack     consumer has taken the matrix
//   o_mat     assembled matrix, o_mat[k] = k-th byte of the frame
//   o_done    high while a complete frame is held
//   o_count   number of bytes stored in the current frame
//   o_overrun sticky, a byte was dropped while a frame was pending
//   o_timeout one-cycle pulse when a partial frame is discarded
// Modports: master drives the inputs (receiver/core side), slave is rx_buffer.
interface rx_buffer_if #(
    parameter int N_BYTES = 9
);
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_ack;
    logic [7:0] o_mat [N_BYTES];
    logic       o_done;
    logic [3:0] o_count;
    logic       o_overrun;
    logic       o_timeout;

    modport master (
        output i_valid, i_data, i_ack,
        input  o_mat, o_done, o_count, o_overrun, o_timeout
    );

    modport slave (
        input  i_valid, i_data, i_ack,
        output o_mat, o_done, o_count, o_overrun, o_timeout
    );
endinterface

// File: rtl/rx_buffer.sv
// rtl/rx_buffer.sv - collects received bytes into an N_BYTES matrix and holds it until acknowledged
//
// Purpose: assembles a frame of N_BYTES bytes, presents it with o_done until the
// consumer acks, abandons a partial frame after TIMEOUT_CYCLES idle clocks and
// flags bytes dropped while a finished frame is pending.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    rx_buffer_if slave: i_valid/i_data/i_ack in, o_mat/o_done/o_count/o_overrun/o_timeout out
module rx_buffer #(
    parameter int N_BYTES        = 9,
    parameter int TIMEOUT_CYCLES = 12000000,
    parameter int CNT_W          = 24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    rx_buffer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [3:0]       LAST_IDX = 4'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tcnt, tcnt_nxt;
    logic             expired;
    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [3:0]       count_nxt;
    logic             done_nxt, overrun_nxt, timeout_nxt;

    // An arriving byte always beats the timeout in the same cycle.
    assign expired = TO_EN && !bus.i_valid && (tcnt == TO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.i_valid) state_nxt = FILL;
            FILL: begin
                if (bus.i_valid && bus.o_count == LAST_IDX) state_nxt = DONE;
                else if (expired)                           state_nxt = IDLE;
            end
            DONE: if (bus.i_ack) state_nxt = bus.i_valid ? FILL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_idx      = bus.o_count;
        count_nxt   = bus.o_count;
        tcnt_nxt    = tcnt;
        overrun_nxt = bus.o_overrun;
        timeout_nxt = 1'b0;
        done_nxt    = (state_nxt == DONE);
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    wr_en     = 1'b1;
                    wr_idx    = 4'd0;
                    count_nxt = 4'd1;
                    tcnt_nxt  = '0;
                end
            end
            FILL: begin
                if (bus.i_valid) begin
                    wr_en     = 1'b1;
                    count_nxt = bus.o_count + 4'd1;
                    tcnt_nxt  = '0;
                end else if (TO_EN) begin
                    if (expired) begin
                        tcnt_nxt    = '0;
                        count_nxt   = 4'd0;
                        timeout_nxt = 1'b1;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
            end
            DONE: begin
                tcnt_nxt = '0;
                if (bus.i_ack) begin
                    overrun_nxt = 1'b0;
                    count_nxt   = 4'd0;
                    // Ack and byte together: the byte opens the next frame.
                    if (bus.i_valid) begin
                        wr_en     = 1'b1;
                        wr_idx    = 4'd0;
                        count_nxt = 4'd1;
                    end
                end else if (bus.i_valid) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tcnt          <= '0;
            bus.o_count   <= 4'd0;
            bus.o_done    <= 1'b0;
            bus.o_overrun <= 1'b0;
            bus.o_timeout <= 1'b0;
            for (int k = 0; k < N_BYTES; k++) begin
                bus.o_mat[k] <= 8'd0;
            end
        end else begin
            tcnt          <= tcnt_nxt;
            bus.o_count   <= count_nxt;
            bus.o_done    <= done_nxt;
            bus.o_overrun <= overrun_nxt;
            bus.o_timeout <= timeout_nxt;
            if (wr_en) begin
                bus.o_mat[wr_idx] <= bus.i_data;
            end
        end
    end
endmodule

// File: tb/tb_rx_buffer.sv
// tb/tb_rx_buffer.sv - self-checking bench for rx_buffer against a frame-level reference model
module tb_rx_buffer;
    localparam int NB = 9;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_buffer_if #(.N_BYTES(NB)) bus ();

    rx_buffer #(.N_BYTES(NB), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a frame buffer, a held flag and a count of idle clocks since the last byte.
    logic [7:0] m_mat [NB];
    int         m_count;
    int         m_idle;
    bit         m_done, m_over, m_to;

    int cyc, to_pulses, to_cyc, last_strobe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) m_mat[k] = 8'h00;
        m_count = 0;
        m_idle  = 0;
        m_done  = 0;
        m_over  = 0;
        m_to    = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit a);
        m_to = 0;
        if (m_done) begin
            if (a) begin
                m_done  = 0;
                m_over  = 0;
                m_count = 0;
                if (v) begin
                    m_mat[0] = d;
                    m_count  = 1;
                    m_idle   = 0;
                end
            end else if (v) begin
                m_over = 1;
            end
        end else if (v) begin
            m_mat[m_count] = d;
            m_count++;
            m_idle = 0;
            if (m_count == NB) m_done = 1;
        end else if (m_count > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_idle  = 0;
                m_count = 0;
                m_to    = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_done"},    32'(bus.o_done),    32'(m_done));
        chk({tag, "_count"},   32'(bus.o_count),   32'(m_count));
        chk({tag, "_overrun"}, 32'(bus.o_overrun), 32'(m_over));
        chk({tag, "_timeout"}, 32'(bus.o_timeout), 32'(m_to));
        for (int k = 0; k < NB; k++)
            chk($sformatf("%s_mat%0d", tag, k), 32'(bus.o_mat[k]), 32'(m_mat[k]));
    endtask

    task automatic step(input string tag, input bit v, input logic [7:0] d, input bit a);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ack   = a;
        @(posedge clk);
        #1;
        cyc++;
        if (v) last_strobe = cyc;
        if (bus.o_timeout === 1'b1) begin
            to_pulses++;
            to_cyc = cyc;
        end
        model_step(v, d, a);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int p_valid;
        int p_ack;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_ack   = 1'b0;
        cyc = 0; to_pulses = 0; to_cyc = 0; last_strobe = 0;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Frame with idle gaps between strobes
        for (int i = 0; i < NB; i++) begin
            step("gap", 1'b1, 8'(i + 1), 1'b0);
            if (i != NB - 1) idle("gap_idle", 3);
        end
        chk("gap_done_const", 32'(bus.o_done), 32'd1);
        chk("gap_mat8_const", 32'(bus.o_mat[8]), 32'h09);
        step("gap_ack", 1'b0, 8'h00, 1'b1);

        // Back-to-back frame
        for (int i = 0; i < NB; i++) step("b2b", 1'b1, 8'(8'hA0 + i), 1'b0);
        chk("b2b_mat8_const", 32'(bus.o_mat[8]), 32'hA8);

        // Overrun while DONE, then ack clears it
        step("ovr", 1'b1, 8'hFF, 1'b0);
        chk("ovr_const", 32'(bus.o_overrun), 32'd1);
        chk("ovr_mat0_const", 32'(bus.o_mat[0]), 32'hA0);
        step("ovr_ack", 1'b0, 8'h00, 1'b1);
        chk("ovr_ack_count_const", 32'(bus.o_count), 32'd0);

        // Ack coincident with a byte starts the next frame
        for (int i = 0; i < NB; i++) step("fill3", 1'b1, 8'(8'h30 + i), 1'b0);
        step("ackv", 1'b1, 8'h5A, 1'b1);
        chk("ackv_count_const", 32'(bus.o_count), 32'd1);
        chk("ackv_mat0_const", 32'(bus.o_mat[0]), 32'h5A);
        idle("ackv_idle", 20);

        // Timeout: 4 bytes then idle, exactly one pulse 16 clocks after the last strobe
        to_pulses = 0;
        for (int i = 0; i < 4; i++) step("to", 1'b1, 8'(8'h40 + i), 1'b0);
        idle("to_idle", 24);
        chk("to_pulses", 32'(to_pulses), 32'd1);
        chk("to_latency", 32'(to_cyc - last_strobe), 32'(TO));
        for (int i = 0; i < NB; i++) step("after_to", 1'b1, 8'(8'h60 + i), 1'b0);
        step("after_to_ack", 1'b0, 8'h00, 1'b1);

        // Strobe on the 15th idle clock keeps the frame alive
        to_pulses = 0;
        for (int i = 0; i < 4; i++) step("keep", 1'b1, 8'(8'h70 + i), 1'b0);
        idle("keep_idle", TO - 2);
        for (int i = 4; i < NB; i++) step("keep_tail", 1'b1, 8'(8'h70 + i), 1'b0);
        chk("keep_no_pulse", 32'(to_pulses), 32'd0);
        chk("keep_done_const", 32'(bus.o_done), 32'd1);
        step("keep_ack", 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h90 + i), 1'b0);
        bus.i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.o_count), 32'd0);
        chk("arst_mat0", 32'(bus.o_mat[0]), 32'd0);
        model_reset();
        check_all("arst");
        #2;
        rst = 1'b0;
        step("post_rst", 1'b1, 8'hC3, 1'b0);
        chk("post_rst_mat0_const", 32'(bus.o_mat[0]), 32'hC3);
        chk("post_rst_mat1_const", 32'(bus.o_mat[1]), 32'h00);

        // Randomized traffic in bursts of differing density
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0:       p_valid = 3;
                    1:       p_valid = 30;
                    default: p_valid = 80;
                endcase
                p_ack = $urandom_range(5, 30);
            end
            step("rnd", ($urandom_range(0, 99) < p_valid), 8'($urandom),
                 ($urandom_range(0, 99) < p_ack));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
